// File: rtl/sh_rf_pkg.sv
// Shared types and constants for the SH2 register-file write scheduler.
// Used by sh_rf_wr_sched and sh_rf_ld_fifo.
package sh_rf_pkg;

    localparam int RF_NREG    = 17;
    localparam int RF_PR_ADDR = 16;

    typedef logic [4:0] rf_addr_t;

    typedef struct packed {
        logic        valid;
        rf_addr_t    addr;
        logic [31:0] data;
    } rf_wr_t;

    // Addresses at or above nreg are not tracked by the load scoreboard.
    function automatic logic addr_tracked(input rf_addr_t a, input int nreg);
        return int'(a) < nreg;
    endfunction

endpackage

// File: rtl/sh_rf_ld_fifo.sv
// Load-return FIFO with per-entry valid bits, an address-match kill port and
// 'contains address' lookups for the two register read ports.
module sh_rf_ld_fifo
    import sh_rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  rf_addr_t    push_addr,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        kill_en,
    input  rf_addr_t    kill_addr,
    input  rf_addr_t    ra_addr,
    input  rf_addr_t    rb_addr,
    output rf_wr_t      head,
    output logic [2:0]  count,
    output logic        ra_hit,
    output logic        rb_hit
);

    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    rf_wr_t           mem_reg [DEPTH];
    logic [1:0]       rd_ptr_reg;
    logic [1:0]       wr_ptr_reg;
    logic [2:0]       count_reg;
    logic [DEPTH-1:0] ra_match;
    logic [DEPTH-1:0] rb_match;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Popped slots lose their valid bit so lookups never see stale entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_ptr_reg == 2'(i)) begin
                    mem_reg[i] <= '{valid: !(kill_en && push_addr == kill_addr),
                                    addr:  push_addr,
                                    data:  push_data};
                end else if ((pop && rd_ptr_reg == 2'(i)) ||
                             (kill_en && mem_reg[i].addr == kill_addr)) begin
                    mem_reg[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            count_reg <= count_reg + 3'(push) - 3'(pop);
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr_reg == 2'(i)) begin
                head = mem_reg[i];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign ra_match[gi] = mem_reg[gi].valid && (mem_reg[gi].addr == ra_addr);
        assign rb_match[gi] = mem_reg[gi].valid && (mem_reg[gi].addr == rb_addr);
    end

    assign ra_hit = |ra_match;
    assign rb_hit = |rb_match;
    assign count  = count_reg;

endmodule

// File: rtl/sh_rf_wr_sched.sv
// SH2 register-file write-port scheduler and load scoreboard.
// Optional macro SH_RF_LD_BYPASS_EN: zero-latency load return when the FIFO is empty.
module sh_rf_wr_sched
    import sh_rf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREG  = RF_NREG
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        EX_WE,
    input  logic [4:0]  EX_ADDR,
    input  logic [31:0] EX_D,
    input  logic        LD_ISSUE,
    input  logic [4:0]  LD_ISSUE_ADDR,
    input  logic        LD_RET,
    input  logic [4:0]  LD_RET_ADDR,
    input  logic [31:0] LD_RET_D,
    output logic        LD_RDY,
    input  logic [4:0]  RA_ADDR,
    input  logic [4:0]  RB_ADDR,
    output logic        RA_HAZ,
    output logic        RB_HAZ,
    output logic [4:0]  RF_WA_ADDR,
    output logic [31:0] RF_WA_D,
    output logic        RF_WAE
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] kill_reg;
    logic [NREG-1:0] kill_next;
    rf_addr_t        last_addr_reg;
    logic [31:0]     last_d_reg;

    rf_wr_t      head;
    logic [2:0]  count;
    logic        fifo_empty;
    logic        ld_rdy;
    logic        ret_killed;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        ra_hit;
    logic        rb_hit;
    logic        wae;
    rf_addr_t    wa_addr;
    logic [31:0] wa_d;

    assign fifo_empty = (count == 3'd0);
    assign ld_rdy     = (count < 3'(DEPTH));
    assign ret_killed = addr_tracked(LD_RET_ADDR, NREG) && kill_reg[LD_RET_ADDR];

`ifdef SH_RF_LD_BYPASS_EN
    assign bypass = LD_RET && ld_rdy && !ret_killed && fifo_empty && !EX_WE && CE;
`else
    assign bypass = 1'b0;
`endif

    // A return to a killed register is consumed here and never reaches the FIFO.
    assign push = LD_RET && ld_rdy && !ret_killed && !bypass;
    assign pop  = CE && !EX_WE && !fifo_empty;

    sh_rf_ld_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (push),
        .push_addr(LD_RET_ADDR),
        .push_data(LD_RET_D),
        .pop      (pop),
        .kill_en  (CE && EX_WE),
        .kill_addr(EX_ADDR),
        .ra_addr  (RA_ADDR),
        .rb_addr  (RB_ADDR),
        .head     (head),
        .count    (count),
        .ra_hit   (ra_hit),
        .rb_hit   (rb_hit)
    );

    // A new issue overrides a same-cycle return: busy stays set, kill is cleared.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
        logic issue_hit;
        logic ret_hit;
        logic ex_hit;
        assign issue_hit     = CE && LD_ISSUE && (LD_ISSUE_ADDR == 5'(gi));
        assign ret_hit       = LD_RET && (LD_RET_ADDR == 5'(gi));
        assign ex_hit        = CE && EX_WE && (EX_ADDR == 5'(gi));
        assign busy_next[gi] = issue_hit || (busy_reg[gi] && !ret_hit);
        assign kill_next[gi] = !issue_hit && !ret_hit &&
                               (kill_reg[gi] || (ex_hit && busy_reg[gi]));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_reg <= '0;
            kill_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            kill_reg <= kill_next;
        end
    end

    always_comb begin
        wae     = 1'b0;
        wa_addr = last_addr_reg;
        wa_d    = last_d_reg;
        if (EX_WE) begin
            wae     = 1'b1;
            wa_addr = EX_ADDR;
            wa_d    = EX_D;
        end else if (!fifo_empty && head.valid) begin
            wae     = 1'b1;
            wa_addr = head.addr;
            wa_d    = head.data;
        end else if (bypass) begin
            wae     = 1'b1;
            wa_addr = LD_RET_ADDR;
            wa_d    = LD_RET_D;
        end
    end

    // Address/data hold their last driven value while no write is offered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_addr_reg <= '0;
            last_d_reg    <= '0;
        end else if (wae) begin
            last_addr_reg <= wa_addr;
            last_d_reg    <= wa_d;
        end
    end

    assign RF_WAE     = wae;
    assign RF_WA_ADDR = wa_addr;
    assign RF_WA_D    = wa_d;
    assign LD_RDY     = ld_rdy;

    assign RA_HAZ = addr_tracked(RA_ADDR, NREG) && (busy_reg[RA_ADDR] || ra_hit) &&
                    !(bypass && RA_ADDR == LD_RET_ADDR);
    assign RB_HAZ = addr_tracked(RB_ADDR, NREG) && (busy_reg[RB_ADDR] || rb_hit) &&
                    !(bypass && RB_ADDR == LD_RET_ADDR);

    ld_ret_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
        LD_RET |-> ld_rdy);

    ld_issue_to_busy: assert property (@(posedge CLK) disable iff (!RST_N)
        (CE && LD_ISSUE && addr_tracked(LD_ISSUE_ADDR, NREG)) |->
        (!busy_reg[LD_ISSUE_ADDR] || (LD_RET && LD_RET_ADDR == LD_ISSUE_ADDR)));

endmodule

// File: tb/tb_sh_rf_wr_sched.sv
// Scoreboard bench for sh_rf_wr_sched: every committed write (CE && RF_WAE)
// is popped against the expected-write queue filled when stimulus is driven.
module tb_sh_rf_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        ex_we;
    logic [4:0]  ex_addr;
    logic [31:0] ex_d;
    logic        ld_issue;
    logic [4:0]  ld_issue_addr;
    logic        ld_ret;
    logic [4:0]  ld_ret_addr;
    logic [31:0] ld_ret_d;
    logic        ld_rdy;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        ra_haz;
    logic        rb_haz;
    logic [4:0]  rf_wa_addr;
    logic [31:0] rf_wa_d;
    logic        rf_wae;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] sb_e;

    always #5 clk = ~clk;

    sh_rf_wr_sched #(.DEPTH(2), .NREG(17)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .CE           (ce),
        .EX_WE        (ex_we),
        .EX_ADDR      (ex_addr),
        .EX_D         (ex_d),
        .LD_ISSUE     (ld_issue),
        .LD_ISSUE_ADDR(ld_issue_addr),
        .LD_RET       (ld_ret),
        .LD_RET_ADDR  (ld_ret_addr),
        .LD_RET_D     (ld_ret_d),
        .LD_RDY       (ld_rdy),
        .RA_ADDR      (ra_addr),
        .RB_ADDR      (rb_addr),
        .RA_HAZ       (ra_haz),
        .RB_HAZ       (rb_haz),
        .RF_WA_ADDR   (rf_wa_addr),
        .RF_WA_D      (rf_wa_d),
        .RF_WAE       (rf_wae)
    );

    // Committed register-file writes are scored against the expected queue.
    always @(negedge clk) begin
        if (rst_n && ce && rf_wae) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got write R%0d=%h, expected no write", rf_wa_addr, rf_wa_d);
            end else begin
                sb_e = exp_q.pop_front();
                if ({rf_wa_addr, rf_wa_d} !== sb_e) begin
                    n_fail++;
                    $display("FAIL sb_write: got R%0d=%h, expected R%0d=%h", rf_wa_addr, rf_wa_d, sb_e[36:32], sb_e[31:0]);
                end else begin
                    $display("write R%0d=%h ok", rf_wa_addr, rf_wa_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; ex_we = 1'b0; ex_addr = '0; ex_d = '0;
        ld_issue = 1'b0; ld_issue_addr = '0; ld_ret = 1'b0; ld_ret_addr = '0; ld_ret_d = '0;
        ra_addr = 5'd3; rb_addr = 5'd3;
        repeat (2) @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0) begin n_fail++; $display("FAIL reset_wae: got %b, expected 0", rf_wae); end
        n_checks++; if (ld_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ld_rdy: got %b, expected 1", ld_rdy); end
        n_checks++; if (ra_haz !== 1'b0 || rb_haz !== 1'b0) begin n_fail++; $display("FAIL reset_haz: got %b%b, expected 00", ra_haz, rb_haz); end
        n_checks++; if (rf_wa_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, expected 0", rf_wa_addr); end
        n_checks++; if (rf_wa_d !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", rf_wa_d); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        ld_issue = 1'b1; ld_issue_addr = 5'd3; ra_addr = 5'd3;
        tick();
        ld_issue = 1'b0;
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b1) begin n_fail++; $display("FAIL basic_haz_pending: got %b, expected 1", ra_haz); end
        tick();
        ld_ret = 1'b1; ld_ret_addr = 5'd3; ld_ret_d = 32'hDEADBEEF;
        exp_q.push_back({5'd3, 32'hDEADBEEF});
`ifndef SH_RF_LD_BYPASS_EN
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0) begin n_fail++; $display("FAIL basic_latency: got wae %b on return cycle, expected 0", rf_wae); end
`endif
        tick();
        ld_ret = 1'b0;
`ifndef SH_RF_LD_BYPASS_EN
        @(negedge clk);
        n_checks++; if ({rf_wae, rf_wa_addr, rf_wa_d} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL basic_write: got wae=%b R%0d=%h, expected wae=1 R3=deadbeef", rf_wae, rf_wa_addr, rf_wa_d);
        end
        n_checks++; if (ra_haz !== 1'b1) begin n_fail++; $display("FAIL basic_haz_queued: got %b, expected 1", ra_haz); end
        tick();
`endif
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b0) begin n_fail++; $display("FAIL basic_haz_clear: got %b, expected 0", ra_haz); end
        n_checks++; if (rf_wae !== 1'b0 || rf_wa_addr !== 5'd3) begin n_fail++; $display("FAIL basic_hold: got wae=%b addr=%0d, expected wae=0 addr=3", rf_wae, rf_wa_addr); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_priority();
        ld_issue = 1'b1; ld_issue_addr = 5'd5;
        tick();
        ld_issue = 1'b0;
        ex_we = 1'b1; ex_addr = 5'd1; ex_d = 32'h11111111;
        ld_ret = 1'b1; ld_ret_addr = 5'd5; ld_ret_d = 32'h5A5A5A5A;
        repeat (3) exp_q.push_back({5'd1, 32'h11111111});
        exp_q.push_back({5'd5, 32'h5A5A5A5A});
        tick();
        ld_ret = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b1 || rf_wa_addr !== 5'd1) begin n_fail++; $display("FAIL prio_ex_cycle3: got wae=%b addr=%0d, expected wae=1 addr=1", rf_wae, rf_wa_addr); end
        tick();
        ex_we = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wa_addr !== 5'd5 || rf_wa_d !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL prio_ld_cycle4: got R%0d=%h, expected R5=5a5a5a5a", rf_wa_addr, rf_wa_d); end
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b, expected 0", rf_wae); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL prio_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_full();
        ld_issue = 1'b1; ld_issue_addr = 5'd4;
        tick();
        ld_issue_addr = 5'd6;
        tick();
        ld_issue = 1'b0;
        ex_we = 1'b1; ex_addr = 5'd10; ex_d = 32'hA0A0A0A0;
        repeat (3) exp_q.push_back({5'd10, 32'hA0A0A0A0});
        exp_q.push_back({5'd4, 32'h44444444});
        exp_q.push_back({5'd6, 32'h66666666});
        ld_ret = 1'b1; ld_ret_addr = 5'd4; ld_ret_d = 32'h44444444;
        tick();
        ld_ret_addr = 5'd6; ld_ret_d = 32'h66666666;
        tick();
        ld_ret = 1'b0;
        @(negedge clk);
        n_checks++; if (ld_rdy !== 1'b0) begin n_fail++; $display("FAIL full_ld_rdy_low: got %b, expected 0", ld_rdy); end
        tick();
        ex_we = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wa_addr !== 5'd4 || ld_rdy !== 1'b0) begin n_fail++; $display("FAIL full_first: got addr=%0d rdy=%b, expected addr=4 rdy=0", rf_wa_addr, ld_rdy); end
        tick();
        @(negedge clk);
        n_checks++; if (rf_wa_addr !== 5'd6 || ld_rdy !== 1'b1) begin n_fail++; $display("FAIL full_second: got addr=%0d rdy=%b, expected addr=6 rdy=1", rf_wa_addr, ld_rdy); end
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0 || ld_rdy !== 1'b1) begin n_fail++; $display("FAIL full_empty: got wae=%b rdy=%b, expected wae=0 rdy=1", rf_wae, ld_rdy); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_waw_kill();
        // Busy register overwritten by EX: the late load data must be dropped.
        ld_issue = 1'b1; ld_issue_addr = 5'd7;
        tick();
        ld_issue = 1'b0;
        ex_we = 1'b1; ex_addr = 5'd7; ex_d = 32'h5;
        exp_q.push_back({5'd7, 32'h5});
        tick();
        ex_we = 1'b0;
        ld_ret = 1'b1; ld_ret_addr = 5'd7; ld_ret_d = 32'h9; ra_addr = 5'd7;
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b1 || rf_wae !== 1'b0) begin n_fail++; $display("FAIL kill_ret_cycle: got haz=%b wae=%b, expected haz=1 wae=0", ra_haz, rf_wae); end
        tick();
        ld_ret = 1'b0;
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b0 || rf_wae !== 1'b0) begin n_fail++; $display("FAIL kill_after: got haz=%b wae=%b, expected haz=0 wae=0", ra_haz, rf_wae); end
        tick();
        // Queued entry invalidated by a later EX write to the same register.
        ld_issue = 1'b1; ld_issue_addr = 5'd13;
        tick();
        ld_issue = 1'b0;
        ex_we = 1'b1; ex_addr = 5'd1; ex_d = 32'h1;
        ld_ret = 1'b1; ld_ret_addr = 5'd13; ld_ret_d = 32'hD;
        exp_q.push_back({5'd1, 32'h1});
        tick();
        ld_ret = 1'b0; ex_addr = 5'd13; ex_d = 32'h13D; ra_addr = 5'd13;
        exp_q.push_back({5'd13, 32'h13D});
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b1) begin n_fail++; $display("FAIL kill_queued_haz: got %b, expected 1", ra_haz); end
        tick();
        ex_we = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0 || ra_haz !== 1'b0) begin n_fail++; $display("FAIL kill_queued: got wae=%b haz=%b, expected 0 0", rf_wae, ra_haz); end
        tick();
        // Entry pushed in the same cycle as the EX write is invalidated too.
        ld_issue = 1'b1; ld_issue_addr = 5'd12;
        tick();
        ld_issue = 1'b0;
        ex_we = 1'b1; ex_addr = 5'd12; ex_d = 32'hE;
        ld_ret = 1'b1; ld_ret_addr = 5'd12; ld_ret_d = 32'hC; ra_addr = 5'd12;
        exp_q.push_back({5'd12, 32'hE});
        tick();
        ex_we = 1'b0; ld_ret = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0 || ra_haz !== 1'b0) begin n_fail++; $display("FAIL kill_same_cycle: got wae=%b haz=%b, expected 0 0", rf_wae, ra_haz); end
        tick();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL kill_drain: got %0d pending writes, expected 0", exp_q.size()); end
    endtask

    task automatic test_ce_stall();
        ld_issue = 1'b1; ld_issue_addr = 5'd2;
        tick();
        ld_issue = 1'b0; ce = 1'b0;
        ld_ret = 1'b1; ld_ret_addr = 5'd2; ld_ret_d = 32'h22222222; ra_addr = 5'd2;
        exp_q.push_back({5'd2, 32'h22222222});
        tick();
        ld_ret = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b1 || rf_wa_addr !== 5'd2) begin n_fail++; $display("FAIL stall_offer: got wae=%b addr=%0d, expected wae=1 addr=2", rf_wae, rf_wa_addr); end
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b1 || ra_haz !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got wae=%b haz=%b, expected 1 1", rf_wae, ra_haz); end
        tick();
        ce = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0 || ra_haz !== 1'b0) begin n_fail++; $display("FAIL stall_popped: got wae=%b haz=%b, expected 0 0", rf_wae, ra_haz); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_bypass();
        ld_issue = 1'b1; ld_issue_addr = 5'd8;
        tick();
        ld_issue = 1'b0;
        ld_ret = 1'b1; ld_ret_addr = 5'd8; ld_ret_d = 32'h0000CAFE; ra_addr = 5'd8;
        exp_q.push_back({5'd8, 32'h0000CAFE});
        @(negedge clk);
`ifdef SH_RF_LD_BYPASS_EN
        n_checks++; if ({rf_wae, rf_wa_addr, rf_wa_d} !== {1'b1, 5'd8, 32'h0000CAFE}) begin
            n_fail++; $display("FAIL bypass_same_cycle: got wae=%b R%0d=%h, expected wae=1 R8=0000cafe", rf_wae, rf_wa_addr, rf_wa_d);
        end
        n_checks++; if (ra_haz !== 1'b0) begin n_fail++; $display("FAIL bypass_haz: got %b, expected 0", ra_haz); end
`else
        n_checks++; if (rf_wae !== 1'b0 || ra_haz !== 1'b1) begin n_fail++; $display("FAIL nobypass_ret: got wae=%b haz=%b, expected 0 1", rf_wae, ra_haz); end
`endif
        tick();
        ld_ret = 1'b0;
        @(negedge clk);
`ifdef SH_RF_LD_BYPASS_EN
        n_checks++; if (rf_wae !== 1'b0 || ld_rdy !== 1'b1) begin n_fail++; $display("FAIL bypass_fifo_empty: got wae=%b rdy=%b, expected 0 1", rf_wae, ld_rdy); end
`else
        n_checks++; if (rf_wae !== 1'b1 || rf_wa_addr !== 5'd8) begin n_fail++; $display("FAIL nobypass_write: got wae=%b addr=%0d, expected 1 8", rf_wae, rf_wa_addr); end
`endif
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0 || ra_haz !== 1'b0) begin n_fail++; $display("FAIL bypass_idle: got wae=%b haz=%b, expected 0 0", rf_wae, ra_haz); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bypass_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d9, d11, d20;
        d9 = $urandom; d11 = $urandom; d20 = $urandom;
        ld_issue = 1'b1; ld_issue_addr = 5'd9;
        tick();
        ld_issue_addr = 5'd11;
        tick();
        ld_issue = 1'b0; ra_addr = 5'd9; rb_addr = 5'd11;
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b1 || rb_haz !== 1'b1) begin n_fail++; $display("FAIL b2b_haz: got %b%b, expected 11", ra_haz, rb_haz); end
        tick();
        ld_ret = 1'b1; ld_ret_addr = 5'd9; ld_ret_d = d9;
        exp_q.push_back({5'd9, d9});
        tick();
        ld_ret_addr = 5'd11; ld_ret_d = d11;
        exp_q.push_back({5'd11, d11});
        tick();
        ld_ret = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        n_checks++; if (ra_haz !== 1'b0 || rb_haz !== 1'b0) begin n_fail++; $display("FAIL b2b_haz_clear: got %b%b, expected 00", ra_haz, rb_haz); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending writes, expected 0", exp_q.size()); end
        // Untracked address: forwarded to the write port, ignored by the scoreboard.
        tick();
        ex_we = 1'b1; ex_addr = 5'd20; ex_d = d20; ld_issue = 1'b1; ld_issue_addr = 5'd20; rb_addr = 5'd20;
        exp_q.push_back({5'd20, d20});
        @(negedge clk);
        n_checks++; if (rf_wa_addr !== 5'd20 || rb_haz !== 1'b0) begin n_fail++; $display("FAIL oor_forward: got addr=%0d haz=%b, expected 20 0", rf_wa_addr, rb_haz); end
        tick();
        ex_we = 1'b0; ld_issue = 1'b0;
        @(negedge clk);
        n_checks++; if (rb_haz !== 1'b0) begin n_fail++; $display("FAIL oor_no_busy: got %b, expected 0", rb_haz); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL oor_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_mid_reset();
        ld_issue = 1'b1; ld_issue_addr = 5'd14;
        tick();
        ld_issue_addr = 5'd15;
        tick();
        ld_issue = 1'b0;
        ex_we = 1'b1; ex_addr = 5'd0; ex_d = 32'h0F0F0F0F;
        ld_ret = 1'b1; ld_ret_addr = 5'd14; ld_ret_d = 32'h14141414;
        exp_q.push_back({5'd0, 32'h0F0F0F0F});
        tick();
        ld_ret = 1'b0; ex_we = 1'b0; ce = 1'b0; ra_addr = 5'd14; rb_addr = 5'd15;
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b1 || ra_haz !== 1'b1 || rb_haz !== 1'b1) begin n_fail++; $display("FAIL midrst_before: got wae=%b haz=%b%b, expected 1 11", rf_wae, ra_haz, rb_haz); end
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0 || ld_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_port: got wae=%b rdy=%b, expected 0 1", rf_wae, ld_rdy); end
        n_checks++; if (ra_haz !== 1'b0 || rb_haz !== 1'b0) begin n_fail++; $display("FAIL midrst_haz: got %b%b, expected 00", ra_haz, rb_haz); end
        n_checks++; if (rf_wa_addr !== 5'd0 || rf_wa_d !== 32'd0) begin n_fail++; $display("FAIL midrst_hold: got R%0d=%h, expected R0=00000000", rf_wa_addr, rf_wa_d); end
        tick();
        rst_n = 1'b1; ce = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (rf_wae !== 1'b0) begin n_fail++; $display("FAIL midrst_discard: got %b, expected 0", rf_wae); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_drain: got %0d pending writes, expected 0", exp_q.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_priority();
        test_full();
        test_waw_kill();
        test_ce_stall();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
